// File: rtl/i2c_sensor_target.sv
// -----------------------------------------------------------------------------
// i2c_sensor_target
//
// I2C target for a simple sensor. It answers to a 7-bit address. Reads return
// a 16-bit sample, high byte first. Writes hand each received byte to the
// host logic.
//
// Everything runs in the clk domain. scl and sda are oversampled through
// 2-flop synchronizers, and all bus events are derived from the synchronized
// copies.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   scl          I2C clock from the master (asynchronous to clk)
//   sda          I2C data, open drain: driven low or released to high-Z
//   sample_data  16-bit value returned on reads
//   wr_data      last byte written by the master
//   wr_valid     one-clk pulse when wr_data updates
//   rd_done      one-clk pulse when the master NACKs a read byte
//   busy         high while this target owns the current transaction
// -----------------------------------------------------------------------------
module i2c_sensor_target #(
   parameter logic [6:0] DEV_ADDR = 7'b1001_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl,
   inout  wire         sda,
   input  logic [15:0] sample_data,
   output logic [7:0]  wr_data,
   output logic        wr_valid,
   output logic        rd_done,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_TX_BYTE,
      S_TX_ACK,
      S_RX_BYTE,
      S_RX_ACK,
      S_WAIT_STOP
   } state_t;

   state_t      r_state;

   // Synchronizers plus one history flop for edge detection
   logic        r_scl_s1, r_scl_s2, r_scl_prev;
   logic        r_sda_s1, r_sda_s2, r_sda_prev;

   logic [7:0]  r_shift;     // address / write-data shift register
   logic [3:0]  r_bit_cnt;   // bits shifted in, or bits driven out
   logic [15:0] r_shadow;    // sample snapshot taken at address match
   logic        r_byte_idx;  // 0: high byte, 1: low byte
   logic        r_sda_low;   // 1 pulls sda low

   logic        w_start;
   logic        w_stop;
   logic        w_scl_rise;
   logic        w_scl_fall;
   logic        w_addr_match;
   logic [7:0]  w_tx_byte;
   logic        w_tx_bit;

   // NOTE: open-drain output. The target only ever pulls low; a '1' is sent
   // by releasing the line and letting the bus pull-up win.
   assign sda = r_sda_low ? 1'b0 : 1'bz;

   // Bus conditions come from synchronized values only. START and STOP are
   // sda edges while scl is stable high.
   assign w_start    =  r_scl_s2 &  r_scl_prev &  r_sda_prev & ~r_sda_s2;
   assign w_stop     =  r_scl_s2 &  r_scl_prev & ~r_sda_prev &  r_sda_s2;
   assign w_scl_rise =  r_scl_s2 & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_s2 &  r_scl_prev;

   assign w_addr_match = (r_shift[7:1] == DEV_ADDR);

   // Bit r_bit_cnt of the current byte, counted from the MSB
   assign w_tx_byte = r_byte_idx ? r_shadow[7:0] : r_shadow[15:8];
   assign w_tx_bit  = w_tx_byte[3'd7 - r_bit_cnt[2:0]];

   // NOTE: every register here is sequential state. Non-blocking assignments
   // keep each flop reading the pre-edge values of the others. The reset is
   // synchronous and covers every flop, including the shadow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_scl_s1   <= 1'b1;
         r_scl_s2   <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_s1   <= 1'b1;
         r_sda_s2   <= 1'b1;
         r_sda_prev <= 1'b1;
         r_shift    <= 8'h00;
         r_bit_cnt  <= 4'd0;
         r_shadow   <= 16'h0000;
         r_byte_idx <= 1'b0;
         r_sda_low  <= 1'b0;
         wr_data    <= 8'h00;
         wr_valid   <= 1'b0;
         rd_done    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         r_scl_s1   <= scl;
         r_scl_s2   <= r_scl_s1;
         r_scl_prev <= r_scl_s2;
         r_sda_s1   <= sda;
         r_sda_s2   <= r_sda_s1;
         r_sda_prev <= r_sda_s2;

         wr_valid <= 1'b0;
         rd_done  <= 1'b0;

         if (w_start) begin
            // Also covers repeated START. busy is left alone so that a
            // write-then-read on the same address stays busy; it is
            // re-evaluated when the new address byte completes.
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_low <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_low <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise && r_bit_cnt != 4'd8) begin
                     r_shift   <= {r_shift[6:0], r_sda_s2};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     r_bit_cnt <= 4'd0;
                     if (w_addr_match) begin
                        r_sda_low <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_ADDR_ACK;
                        if (r_shift[0]) begin
                           // The snapshot isolates the read from later
                           // changes on sample_data.
                           r_shadow   <= sample_data;
                           r_byte_idx <= 1'b0;
                        end
                     end else begin
                        busy    <= 1'b0;
                        r_state <= S_WAIT_STOP;
                     end
                  end
               end

               S_ADDR_ACK: begin
                  // r_shift[0] still holds the R/W bit of the address byte
                  if (w_scl_fall) begin
                     if (r_shift[0]) begin
                        r_sda_low <= ~r_shadow[15];
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_TX_BYTE;
                     end else begin
                        r_sda_low <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_RX_BYTE;
                     end
                  end
               end

               S_TX_BYTE: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_low <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_TX_ACK;
                     end else begin
                        r_sda_low <= ~w_tx_bit;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end

               S_TX_ACK: begin
                  // On ACK, the next byte's MSB goes out at the following
                  // fall, from TX_BYTE with the counter at zero.
                  if (w_scl_rise) begin
                     if (!r_sda_s2) begin
                        r_byte_idx <= ~r_byte_idx;
                        r_bit_cnt  <= 4'd0;
                        r_state    <= S_TX_BYTE;
                     end else begin
                        rd_done <= 1'b1;
                        r_state <= S_WAIT_STOP;
                     end
                  end
               end

               S_RX_BYTE: begin
                  if (w_scl_rise && r_bit_cnt != 4'd8) begin
                     r_shift   <= {r_shift[6:0], r_sda_s2};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     r_sda_low <= 1'b1;
                     wr_data   <= r_shift;
                     wr_valid  <= 1'b1;
                     r_bit_cnt <= 4'd0;
                     r_state   <= S_RX_ACK;
                  end
               end

               S_RX_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_low <= 1'b0;
                     r_state   <= S_RX_BYTE;
                  end
               end

               default: begin
                  // IDLE and WAIT_STOP: ignore bus traffic, keep sda released
                  r_sda_low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_sensor_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_sensor_target
//
// Behavioural I2C master driving i2c_sensor_target. Expected write bytes and
// read bytes are queued when the master issues the transfer. Write bytes are
// popped by a monitor on wr_valid. Read bytes are popped as each byte is
// clocked in.
// -----------------------------------------------------------------------------
module tb_i2c_sensor_target;

   localparam int Q = 5;   // clk cycles per quarter I2C bit

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl = 1'b1;
   logic        m_sda_low = 1'b0;
   logic [15:0] sample_data = 16'h0000;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        rd_done;
   logic        busy;
   wire         sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

   i2c_sensor_target #(.DEV_ADDR(7'b1001_000)) dut (
      .clk         (clk),
      .reset       (reset),
      .scl         (scl),
      .sda         (sda_bus),
      .sample_data (sample_data),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .rd_done     (rd_done),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_wr     = 0;
   int         n_rd     = 0;
   logic [7:0] exp_wr_q[$];
   logic [7:0] exp_rd_q[$];
   logic [7:0] mon_exp;

   // Write-side scoreboard: pop one expected byte per wr_valid pulse
   always @(negedge clk) begin
      if (!reset && wr_valid) begin
         n_wr++;
         n_checks++;
         if (exp_wr_q.size() == 0) begin
            $display("FAIL wr_data: got %h with no byte expected", wr_data);
         end else begin
            mon_exp = exp_wr_q.pop_front();
            if (wr_data !== mon_exp)
               $display("FAIL wr_data: got %h expected %h", wr_data, mon_exp);
            else
               n_pass++;
         end
      end
      if (!reset && rd_done) n_rd++;
   end

   // ---------------- bus master primitives ----------------
   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic m_start();
      m_sda_low = 1'b0; wait_q();
      scl = 1'b1;       wait_q();
      m_sda_low = 1'b1; wait_q();
      scl = 1'b0;       wait_q();
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1; wait_q();
      scl = 1'b1;       wait_q();
      m_sda_low = 1'b0; wait_q();
      wait_q();
   endtask

   task automatic m_write_bit(input logic b);
      m_sda_low = ~b; wait_q();
      scl = 1'b1;     wait_q(); wait_q();
      scl = 1'b0;     wait_q();
   endtask

   task automatic m_read_bit(output logic b);
      m_sda_low = 1'b0; wait_q();
      scl = 1'b1;       wait_q();
      b = sda_bus;      wait_q();
      scl = 1'b0;       wait_q();
   endtask

   task automatic m_write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) m_write_bit(d[i]);
      m_read_bit(ack);
   endtask

   task automatic m_read_byte(input logic ack_it, output logic [7:0] d);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         m_read_bit(b);
         d = {d[6:0], b};
      end
      m_write_bit(ack_it ? 1'b0 : 1'b1);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); else n_pass++;
      n_checks++; if (rd_done !== 1'b0) $display("FAIL reset_rd_done: got %b expected 0", rd_done); else n_pass++;
      n_checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h expected 00", wr_data); else n_pass++;
      n_checks++; if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b expected 1", sda_bus); else n_pass++;
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_read();
      logic       ack;
      logic [7:0] d, e;
      int         rd0;
      rd0 = n_rd;
      sample_data = 16'h1A80;
      exp_rd_q.push_back(8'h1A);
      exp_rd_q.push_back(8'h80);
      m_start();
      m_write_byte(8'h91, ack);
      n_checks++; if (ack !== 1'b0) $display("FAIL read_addr_ack: got %b expected 0", ack); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL read_busy: got %b expected 1", busy); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         m_read_byte(i == 0, d);
         e = exp_rd_q.pop_front();
         n_checks++; if (d !== e) $display("FAIL read_byte%0d: got %h expected %h", i, d, e); else n_pass++;
      end
      m_stop();
      n_checks++; if (n_rd - rd0 != 1) $display("FAIL read_rd_done: got %0d pulses expected 1", n_rd - rd0); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL read_busy_stop: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_mismatch();
      logic ack, b, low_seen, busy_seen;
      int   wr0, rd0;
      wr0 = n_wr; rd0 = n_rd;
      m_start();
      m_write_byte(8'h93, ack);
      low_seen  = ~ack;
      busy_seen = busy;
      for (int i = 0; i < 16; i++) begin
         m_read_bit(b);
         if (!b)  low_seen  = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
      m_stop();
      n_checks++; if (ack !== 1'b1) $display("FAIL mismatch_ack: got %b expected 1", ack); else n_pass++;
      n_checks++; if (low_seen !== 1'b0) $display("FAIL mismatch_sda_low: got %b expected 0", low_seen); else n_pass++;
      n_checks++; if (busy_seen !== 1'b0) $display("FAIL mismatch_busy: got %b expected 0", busy_seen); else n_pass++;
      n_checks++; if (n_wr != wr0 || n_rd != rd0)
         $display("FAIL mismatch_pulses: got wr %0d rd %0d expected 0 0", n_wr - wr0, n_rd - rd0); else n_pass++;
   endtask

   task automatic test_write();
      logic [7:0] bytes [3];
      logic       ack;
      int         wr0;
      bytes = '{8'h90, 8'h5C, 8'hA3};
      wr0 = n_wr;
      m_start();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) exp_wr_q.push_back(bytes[i]);
         m_write_byte(bytes[i], ack);
         n_checks++; if (ack !== 1'b0) $display("FAIL write_ack%0d: got %b expected 0", i, ack); else n_pass++;
      end
      m_stop();
      n_checks++; if (n_wr - wr0 != 2) $display("FAIL write_pulses: got %0d expected 2", n_wr - wr0); else n_pass++;
   endtask

   task automatic test_snapshot();
      logic       ack;
      logic [7:0] d, e;
      int         rd0;
      rd0 = n_rd;
      sample_data = 16'h1A80;
      m_start();
      m_write_byte(8'h91, ack);
      sample_data = 16'hFFFF;
      exp_rd_q.push_back(8'h1A);
      exp_rd_q.push_back(8'h80);
      exp_rd_q.push_back(8'h1A);
      exp_rd_q.push_back(8'h80);
      n_checks++; if (ack !== 1'b0) $display("FAIL snap_addr_ack: got %b expected 0", ack); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         m_read_byte(i < 3, d);
         e = exp_rd_q.pop_front();
         n_checks++; if (d !== e) $display("FAIL snap_byte%0d: got %h expected %h", i, d, e); else n_pass++;
      end
      m_stop();
      n_checks++; if (n_rd - rd0 != 1) $display("FAIL snap_rd_done: got %0d expected 1", n_rd - rd0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic       ack;
      logic [7:0] d, e;
      int         wr0;
      wr0 = n_wr;
      sample_data = 16'hC35A;
      m_start();
      m_write_byte(8'h90, ack);
      exp_wr_q.push_back(8'h01);
      m_write_byte(8'h01, ack);
      n_checks++; if (busy !== 1'b1) $display("FAIL rstart_busy_write: got %b expected 1", busy); else n_pass++;
      m_start();
      n_checks++; if (busy !== 1'b1) $display("FAIL rstart_busy_start: got %b expected 1", busy); else n_pass++;
      exp_rd_q.push_back(8'hC3);
      exp_rd_q.push_back(8'h5A);
      m_write_byte(8'h91, ack);
      n_checks++; if (ack !== 1'b0) $display("FAIL rstart_addr_ack: got %b expected 0", ack); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         m_read_byte(i == 0, d);
         e = exp_rd_q.pop_front();
         n_checks++; if (d !== e) $display("FAIL rstart_byte%0d: got %h expected %h", i, d, e); else n_pass++;
      end
      n_checks++; if (busy !== 1'b1) $display("FAIL rstart_busy_read: got %b expected 1", busy); else n_pass++;
      m_stop();
      n_checks++; if (busy !== 1'b0) $display("FAIL rstart_busy_stop: got %b expected 0", busy); else n_pass++;
      n_checks++; if (n_wr - wr0 != 1) $display("FAIL rstart_wr_pulses: got %0d expected 1", n_wr - wr0); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic       ack;
      logic [7:0] d, e;
      int         rd0;
      sample_data = 16'h1A80;
      m_start();
      m_write_byte(8'h91, ack);
      // Target is now driving the MSB of 8'h1A, a 0
      n_checks++; if (sda_bus !== 1'b0) $display("FAIL midrst_bit_low: got %b expected 0", sda_bus); else n_pass++;
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (sda_bus !== 1'b1) $display("FAIL midrst_sda_release: got %b expected 1", sda_bus); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3 * Q) @(negedge clk);
      n_checks++; if (sda_bus !== 1'b1) $display("FAIL midrst_idle_sda: got %b expected 1", sda_bus); else n_pass++;
      rd0 = n_rd;
      exp_rd_q.push_back(8'h1A);
      exp_rd_q.push_back(8'h80);
      m_start();
      m_write_byte(8'h91, ack);
      n_checks++; if (ack !== 1'b0) $display("FAIL midrst_addr_ack: got %b expected 0", ack); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         m_read_byte(i == 0, d);
         e = exp_rd_q.pop_front();
         n_checks++; if (d !== e) $display("FAIL midrst_byte%0d: got %h expected %h", i, d, e); else n_pass++;
      end
      m_stop();
      n_checks++; if (n_rd - rd0 != 1) $display("FAIL midrst_rd_done: got %0d expected 1", n_rd - rd0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_mismatch();
      test_write();
      test_snapshot();
      test_back_to_back();
      test_reset_mid_read();
      repeat (4) @(negedge clk);
      n_checks++; if (exp_wr_q.size() != 0) $display("FAIL wr_queue_drained: got %0d left expected 0", exp_wr_q.size()); else n_pass++;
      n_checks++; if (exp_rd_q.size() != 0) $display("FAIL rd_queue_drained: got %0d left expected 0", exp_rd_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
